// File: rtl/jb_aes_pkg.sv
// jb_aes_pkg: shared AES-128 definitions for the key expander and cipher pipes.
//   BLOCK_WIDTH  block/key width (128 only)
//   NUM_ROUNDS   AES-128 round count
//   NUM_RKEYS    number of round keys (rounds + initial whitening key)
//   state_e      key-expander FSM states
//   rkey_arr_t   storage type for the full round-key set
//   xtime        GF(2^8) multiply-by-x, used to step Rcon
package jb_aes_pkg;

  localparam int BLOCK_WIDTH = 128;
  localparam int NUM_ROUNDS  = 10;
  localparam int NUM_RKEYS   = NUM_ROUNDS + 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_e;

  typedef logic [NUM_RKEYS-1:0][BLOCK_WIDTH-1:0] rkey_arr_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/jb_aes_sbox.sv
// jb_aes_sbox: AES forward S-box, 256x8 combinational lookup.
//   in_i   byte to substitute
//   out_o  S-box output
module jb_aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Row r of the table holds entries 16r..16r+15, entry 0 in the MSBs.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [7:0] inv_idx;

  assign inv_idx = 8'hff - in_i;
  assign out_o   = SBOX_TBL[{inv_idx, 3'b000} +: 8];

endmodule

// File: rtl/jb_aes_key_expand.sv
// jb_aes_key_expand: iterative AES-128 key schedule, one round key per cycle.
//   clk, rst     clock, synchronous active-high reset
//   start, key   expansion request (sampled in IDLE) and cipher key
//   busy, done   expansion in progress / pulse as round key 10 is written
//   keys_valid   stored key set belongs to the last completed expansion
//   rk_we/idx/data  streaming round-key write port to the encrypt pipe
//   rd_idx, rd_key  combinational read of the stored set (zero past 10)
module jb_aes_key_expand
  import jb_aes_pkg::*;
#(
  parameter int BLOCK_WIDTH = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BLOCK_WIDTH-1:0] key,
  output logic                   busy,
  output logic                   done,
  output logic                   keys_valid,
  output logic                   rk_we,
  output logic [3:0]             rk_idx,
  output logic [BLOCK_WIDTH-1:0] rk_data,
  input  logic [3:0]             rd_idx,
  output logic [BLOCK_WIDTH-1:0] rd_key
);

  state_e                 state_q;
  logic                   busy_q, done_q, keys_valid_q, rk_we_q;
  logic [3:0]             rk_idx_q;
  logic [BLOCK_WIDTH-1:0] rk_data_q;
  logic [7:0]             rcon_q;
  rkey_arr_t              rk_mem_q;

  // Next round key derived from the one currently on the write port.
  logic [31:0]            w0, w1, w2, w3, rot_w, sub_w, t_w;
  logic [31:0]            n0, n1, n2, n3;
  logic [BLOCK_WIDTH-1:0] rk_data_d;

  assign {w0, w1, w2, w3} = rk_data_q;
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    jb_aes_sbox u_sbox (
      .in_i  (rot_w[8*g +: 8]),
      .out_o (sub_w[8*g +: 8])
    );
  end

  assign t_w = sub_w ^ {rcon_q, 24'h000000};
  assign n0  = w0 ^ t_w;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;
  assign rk_data_d = {n0, n1, n2, n3};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      rk_we_q      <= 1'b0;
      rk_idx_q     <= 4'd0;
      rk_data_q    <= '0;
      rcon_q       <= 8'h01;
      rk_mem_q     <= '0;
    end else begin
      done_q <= 1'b0;
      // The key on the port this cycle lands in storage at the closing edge,
      // so the last store coincides with the return to IDLE.
      if (rk_we_q) rk_mem_q[rk_idx_q] <= rk_data_q;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q      <= ST_EXPAND;
            busy_q       <= 1'b1;
            rk_we_q      <= 1'b1;
            rk_idx_q     <= 4'd0;
            rk_data_q    <= key;
            rcon_q       <= 8'h01;
            keys_valid_q <= 1'b0;
          end
        end
        ST_EXPAND: begin
          if (rk_idx_q == 4'(NUM_ROUNDS)) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            rk_we_q      <= 1'b0;
            keys_valid_q <= 1'b1;
          end else begin
            rk_idx_q  <= rk_idx_q + 4'd1;
            rk_data_q <= rk_data_d;
            rcon_q    <= xtime(rcon_q);
            done_q    <= (rk_idx_q == 4'(NUM_ROUNDS - 1));
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_key = '0;
    if (rd_idx <= 4'(NUM_ROUNDS)) rd_key = rk_mem_q[rd_idx];
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = keys_valid_q;
  assign rk_we      = rk_we_q;
  assign rk_idx     = rk_idx_q;
  assign rk_data    = rk_data_q;

endmodule

// File: doc/jb_aes_key_expand.md
JB_AES_KEY_EXPAND -- requirements
Module: jb_aes_key_expand

Interface
REQ-001 Parameter: BLOCK_WIDTH, default 128, AES block/key width; only 128 (AES-128) is supported.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 start  input  1  single-cycle expansion request; sampled only in IDLE.
REQ-005 key  input  BLOCK_WIDTH  cipher key, FIPS-197 byte order; key[127:120] is byte 0, w0 = key[127:96]; captured on the accepted start cycle.
REQ-006 busy  output  1  high while expansion is in progress.
REQ-007 done  output  1  one-cycle pulse when round key 10 is written.
REQ-008 keys_valid  output  1  high when all 11 stored round keys belong to the last completed expansion.
REQ-009 rk_we  output  1  round-key write strobe; this is the streaming port to the downstream encrypt pipe.
REQ-010 rk_idx  output  4  index 0..10 of the round key on rk_data while rk_we is high.
REQ-011 rk_data  output  BLOCK_WIDTH  round key being written.
REQ-012 rd_idx  input  4  read index for the decrypt core, which reads keys in reverse order 10..0.
REQ-013 rd_key  output  BLOCK_WIDTH  stored round key rd_idx, combinational read; all-zero when rd_idx > 10.

Function
REQ-014 FSM states: IDLE, EXPAND; IDLE->EXPAND on start; EXPAND->IDLE after round key 10 is written.
REQ-015 Start accepted at edge T: rk_we=1, rk_idx=0, rk_data=key during cycle T+1; rk_idx=n during cycle T+1+n; rk_idx=10 during cycle T+11; done=1 in cycle T+11 only.
REQ-016 busy=1 from cycle T+1 through T+11 inclusive; busy=0 in the cycle after done.
REQ-017 Round key n = {w4n..w4n+3}, one key per cycle: w4n = w4n-4 ^ SubWord(RotWord(w4n-1)) ^ {Rcon[n],24'h0}; each remaining word = previous word ^ word four positions back.
REQ-018 Rcon sequence: 01,02,04,08,10,20,40,80,1b,36; held in an 8-bit register; next value = xtime(current) (shift left one bit, XOR 8'h1b on carry-out); reset to 01 on each accepted start.
REQ-019 Each written round key is also stored in an internal 11x128 register file at index rk_idx.
REQ-020 start while busy is ignored; the expansion in progress and the captured key are unaffected.
REQ-021 keys_valid drops to 0 in cycle T+1 of any accepted start and rises in the cycle after done.
REQ-022 Changes on key after the accepted start cycle have no effect on the expansion in progress.
REQ-023 start asserted in the same cycle as rst is ignored.
REQ-024 rk_we=0 outside EXPAND; rk_idx and rk_data are don't-care while rk_we=0.

Reset
REQ-025 On rst: state=IDLE, busy=0, done=0, rk_we=0, rk_idx=0, rk_data=0, keys_valid=0, Rcon=01, and all 11 stored keys cleared to 0.
REQ-026 rst during EXPAND aborts the expansion; the next cycle shows the REQ-025 values, and no further rk_we or done pulse is produced.

Structure
REQ-027 Shared package jb_aes_pkg holds: BLOCK_WIDTH, NUM_ROUNDS=10, NUM_RKEYS=11, the FSM state enum, the round-key array typedef and the xtime function.
REQ-028 The S-box is a separate sub-module, jb_aes_sbox (256x8, combinational), instantiated 4 times for SubWord and reused by the encrypt pipe.

Verification
REQ-029 key=2b7e151628aed2a6abf7158809cf4f3c, start -> rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6, done exactly at T+11.
REQ-030 key=0, start -> rk10=b4ef5bcb3e92e21123e951cf6f8f188e; afterwards rd_idx sweep 10..0 returns the stored keys, and rd_idx=15 returns 0.
REQ-031 Second start pulse at T+4 with a different key -> ignored; REQ-029 outputs unchanged; exactly 11 rk_we pulses and 1 done.
REQ-032 rst asserted at T+6 -> no done pulse, keys_valid=0, rd_key=0 for every index; a new start afterwards completes normally.
REQ-033 Back-to-back: start in the cycle after done -> keys_valid 1 for one cycle then 0; second expansion completes with correct keys.
REQ-034 start held high continuously for 30 cycles -> consecutive expansions, each exactly 11 rk_we pulses, one idle cycle between expansions.
